// File: rtl/inst_rom.sv
// inst_rom - instruction memory responder for the openmips core.
//
// Serves the core's instruction-fetch interface combinationally and offers a
// byte-serial load port that fills the memory with a program image while the
// core is held off. Load bytes are assembled big-endian into 32-bit words and
// written one word at a time through a small IDLE/LOAD/COMMIT state machine.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active low
//   ce        fetch enable from the PC register
//   addr      fetch byte address (word index = addr[ADDR_WIDTH+1:2])
//   data      fetched instruction, 0 (NOP) when not fetching or while loading
//   ld_start  one-cycle pulse: start or restart a load at word 0
//   ld_valid  load byte valid
//   ld_byte   load byte
//   ld_last   marks the final byte of the image (qualified by ld_valid)
//   ld_ready  a load byte can be accepted this cycle
//   loading   a load is in progress (core must be held in reset)
//   ld_words  words committed since the last ld_start
//   ld_err    sticky overflow flag, cleared by ld_start or reset

module inst_rom #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           data,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  loading,
    output logic [ADDR_WIDTH:0]   ld_words,
    output logic                  ld_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_WIDTH:0] r_wptr;
    logic [1:0]          r_byteCnt;
    logic [31:0]         r_word;
    logic                r_endOnLast;
    logic [ADDR_WIDTH:0] r_ldWords;
    logic                r_ldErr;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_full;
    logic                w_commitWrite;
    logic [31:0]         w_nextWord;
    logic                w_unusedAddrBits;

    // Byte-lane bits and aliasing bits of the fetch address play no part.
    assign w_unusedAddrBits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    assign ld_ready = (r_state == LOAD) && !ld_start;
    assign loading  = (r_state != IDLE);
    assign ld_words = r_ldWords;
    assign ld_err   = r_ldErr;

    assign w_accept = ld_valid && ld_ready;

    // The write pointer never exceeds DEPTH, so its top bit alone means "full".
    assign w_full = r_wptr[ADDR_WIDTH];

    // A restart during COMMIT discards the pending word along with the rest
    // of the load bookkeeping.
    assign w_commitWrite = (r_state == COMMIT) && !ld_start && !w_full;

    // Big-endian placement: first byte of a word lands in [31:24]. The word
    // register starts at zero, so a word cut short by ld_last is zero-padded.
    always_comb begin
        w_nextWord = r_word;
        case (r_byteCnt)
            2'd0: w_nextWord[31:24] = ld_byte;
            2'd1: w_nextWord[23:16] = ld_byte;
            2'd2: w_nextWord[15:8]  = ld_byte;
            2'd3: w_nextWord[7:0]   = ld_byte;
            default: w_nextWord = r_word;
        endcase
    end

    assign data = (ce && !loading) ? r_mem[addr[ADDR_WIDTH+1:2]] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_byteCnt   <= 2'd0;
            r_word      <= 32'h0;
            r_endOnLast <= 1'b0;
            r_ldWords   <= '0;
            r_ldErr     <= 1'b0;
        end else if (ld_start) begin
            r_state     <= LOAD;
            r_wptr      <= '0;
            r_byteCnt   <= 2'd0;
            r_word      <= 32'h0;
            r_endOnLast <= 1'b0;
            r_ldWords   <= '0;
            r_ldErr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                LOAD: begin
                    if (w_accept) begin
                        r_word <= w_nextWord;
                        if ((r_byteCnt == 2'd3) || ld_last) begin
                            r_state     <= COMMIT;
                            r_byteCnt   <= 2'd0;
                            r_endOnLast <= ld_last;
                        end else begin
                            r_byteCnt <= r_byteCnt + 2'd1;
                        end
                    end
                end
                COMMIT: begin
                    if (w_full) begin
                        r_ldErr <= 1'b1;
                    end else begin
                        r_wptr    <= r_wptr + 1'b1;
                        r_ldWords <= r_ldWords + 1'b1;
                    end
                    r_word      <= 32'h0;
                    r_endOnLast <= 1'b0;
                    r_state     <= r_endOnLast ? IDLE : LOAD;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory contents are deliberately outside the reset domain so a
    // loaded program survives a reset of the load logic.
    always_ff @(posedge clk) begin
        if (w_commitWrite) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= r_word;
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
module tb_inst_rom;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic          ld_start;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_last;
    logic          ld_ready;
    logic          loading;
    logic [AW:0]   ld_words;
    logic          ld_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: image bytes and the memory/flags they should produce.
    logic [7:0]  imgBytes[$];
    logic [31:0] modelMem[DEPTH];
    bit          modelKnown[DEPTH];
    int          modelWords;
    bit          modelErr;
    int          stallLog[$];
    int          lastDoneWait;

    inst_rom #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .addr     (addr),
        .data     (data),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .loading  (loading),
        .ld_words (ld_words),
        .ld_err   (ld_err)
    );

    always #5 clk = ~clk;

    // Word w of the image, big-endian, missing trailing bytes read as zero.
    function automatic logic [31:0] packWord(input int w);
        logic [31:0] word;
        word = 32'h0;
        for (int j = 0; j < 4; j++) begin
            if (4 * w + j < imgBytes.size())
                word = word | (32'(imgBytes[4 * w + j]) << (24 - 8 * j));
        end
        return word;
    endfunction

    task automatic modelLoad();
        int nWords;
        nWords     = (imgBytes.size() + 3) / 4;
        modelWords = 0;
        modelErr   = 0;
        for (int w = 0; w < nWords; w++) begin
            if (w < DEPTH) begin
                modelMem[w]   = packWord(w);
                modelKnown[w] = 1;
                modelWords++;
            end else begin
                modelErr = 1;
            end
        end
    endtask

    task automatic pulseStart();
        @(negedge clk);
        ld_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge after the byte was accepted.
    task automatic sendByte(input logic [7:0] b, input bit last, output int stalls);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        stalls   = 0;
        #1;
        while (!ld_ready && stalls < 10) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!ld_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL byte_accept_timeout: ld_ready=%0b required 1", ld_ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic waitIdle();
        lastDoneWait = 0;
        while (loading && lastDoneWait < 10) begin
            @(negedge clk);
            lastDoneWait++;
        end
        if (loading) begin
            checks++;
            failures++;
            $display("[TB] FAIL load_done_timeout: loading=%0b required 0", loading);
        end
    endtask

    task automatic loadImage(input bit gaps);
        int s;
        pulseStart();
        stallLog.delete();
        for (int i = 0; i < imgBytes.size(); i++) begin
            sendByte(imgBytes[i], i == imgBytes.size() - 1, s);
            stallLog.push_back(s);
            if (gaps && i != imgBytes.size() - 1 && ($urandom % 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        waitIdle();
        modelLoad();
    endtask

    task automatic doFetch(input int idx, output logic [31:0] value);
        logic [31:0] a;
        a = $urandom;
        a[AW+1:2] = idx[AW-1:0];
        @(negedge clk);
        ce   = 1'b1;
        addr = a;
        #1;
        value = data;
        ce = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b0; addr = 32'h0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h0; ld_last = 1'b0;
        #12;
        checks++; if (data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data: got %h want 0", data); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ld_ready: got %b want 0", ld_ready); end
        checks++; if (loading !== 1'b0) begin failures++; $display("[TB] FAIL reset_loading: got %b want 0", loading); end
        checks++; if (ld_words !== '0) begin failures++; $display("[TB] FAIL reset_ld_words: got %0d want 0", ld_words); end
        checks++; if (ld_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_ld_err: got %b want 0", ld_err); end
        @(negedge clk);
        rst = 1'b1;
        ld_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        checks++; if (loading !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL idle_ignores_valid: loading=%b ld_ready=%b want 0 0", loading, ld_ready); end
    endtask

    task automatic test_basic_load();
        logic [31:0] v;
        imgBytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        loadImage(0);
        checks++; if (ld_words !== 3'd2) begin failures++; $display("[TB] FAIL basic_ld_words: got %0d want 2", ld_words); end
        checks++; if (ld_err !== 1'b0) begin failures++; $display("[TB] FAIL basic_ld_err: got %b want 0", ld_err); end
        checks++; if (lastDoneWait !== 1) begin failures++; $display("[TB] FAIL basic_done_latency: got %0d cycles want 1", lastDoneWait); end
        @(negedge clk); ce = 1'b1; addr = 32'h0; #1;
        checks++; if (data !== 32'h12345678) begin failures++; $display("[TB] FAIL basic_fetch0: got %h want 12345678", data); end
        addr = 32'h4; #1;
        checks++; if (data !== 32'h9ABCDEF0) begin failures++; $display("[TB] FAIL basic_fetch4: got %h want 9abcdef0", data); end
        addr = 32'h5; #1;
        checks++; if (data !== 32'h9ABCDEF0) begin failures++; $display("[TB] FAIL basic_fetch5: got %h want 9abcdef0", data); end
        ce = 1'b0; #1;
        checks++; if (data !== 32'h0) begin failures++; $display("[TB] FAIL basic_ce_off: got %h want 0", data); end
        doFetch(1, v);
        checks++; if (v !== 32'h9ABCDEF0) begin failures++; $display("[TB] FAIL basic_alias: got %h want 9abcdef0", v); end
    endtask

    task automatic test_partial_word();
        logic [31:0] v;
        imgBytes = '{8'hAA, 8'hBB};
        loadImage(0);
        checks++; if (ld_words !== 3'd1) begin failures++; $display("[TB] FAIL partial_ld_words: got %0d want 1", ld_words); end
        doFetch(0, v);
        checks++; if (v !== 32'hAABB0000) begin failures++; $display("[TB] FAIL partial_word: got %h want aabb0000", v); end
        doFetch(1, v);
        checks++; if (v !== 32'h9ABCDEF0) begin failures++; $display("[TB] FAIL partial_keeps_word1: got %h want 9abcdef0", v); end
    endtask

    task automatic test_fetch_while_loading();
        int s;
        pulseStart();
        ce = 1'b1; addr = 32'h0; #1;
        checks++; if (data !== 32'h0) begin failures++; $display("[TB] FAIL fetch_during_load: got %h want 0", data); end
        checks++; if (ld_ready !== 1'b1 || loading !== 1'b1) begin failures++; $display("[TB] FAIL start_ready: ld_ready=%b loading=%b want 1 1", ld_ready, loading); end
        ce = 1'b0;
        sendByte(8'hC3, 1, s);
        waitIdle();
        imgBytes = '{8'hC3};
        modelLoad();
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        int exp;
        imgBytes.delete();
        for (int i = 0; i < 13; i++) imgBytes.push_back(8'($urandom));
        loadImage(0);
        for (int i = 0; i < stallLog.size(); i++) begin
            exp = (i > 0 && i % 4 == 0) ? 1 : 0;
            checks++;
            if (stallLog[i] !== exp) begin failures++; $display("[TB] FAIL b2b_stall_byte%0d: got %0d want %0d", i, stallLog[i], exp); end
        end
        checks++; if (ld_words !== 3'(modelWords)) begin failures++; $display("[TB] FAIL b2b_ld_words: got %0d want %0d", ld_words, modelWords); end
        for (int k = 0; k < DEPTH; k++) begin
            doFetch(k, v);
            checks++; if (v !== modelMem[k]) begin failures++; $display("[TB] FAIL b2b_mem%0d: got %h want %h", k, v, modelMem[k]); end
        end
    endtask

    task automatic test_random_images();
        logic [31:0] v;
        for (int it = 0; it < 6; it++) begin
            imgBytes.delete();
            for (int i = 0; i < $urandom_range(1, 20); i++) imgBytes.push_back(8'($urandom));
            loadImage(1);
            checks++; if (ld_words !== 3'(modelWords)) begin failures++; $display("[TB] FAIL rand%0d_ld_words: got %0d want %0d", it, ld_words, modelWords); end
            checks++; if (ld_err !== modelErr) begin failures++; $display("[TB] FAIL rand%0d_ld_err: got %b want %b", it, ld_err, modelErr); end
            for (int k = 0; k < DEPTH; k++) begin
                if (modelKnown[k]) begin
                    doFetch(k, v);
                    checks++; if (v !== modelMem[k]) begin failures++; $display("[TB] FAIL rand%0d_mem%0d: got %h want %h", it, k, v, modelMem[k]); end
                end
            end
        end
    endtask

    task automatic test_overflow_restart();
        logic [31:0] v;
        logic [31:0] first;
        int s;
        imgBytes.delete();
        for (int i = 0; i < 20; i++) imgBytes.push_back(8'(8'h40 + i));
        first = {imgBytes[0], imgBytes[1], imgBytes[2], imgBytes[3]};
        loadImage(0);
        checks++; if (ld_words !== 3'd4) begin failures++; $display("[TB] FAIL ovf_ld_words: got %0d want 4", ld_words); end
        checks++; if (ld_err !== 1'b1) begin failures++; $display("[TB] FAIL ovf_ld_err: got %b want 1", ld_err); end
        doFetch(0, v);
        checks++; if (v !== first) begin failures++; $display("[TB] FAIL ovf_mem0_kept: got %h want %h", v, first); end
        doFetch(3, v);
        checks++; if (v !== modelMem[3]) begin failures++; $display("[TB] FAIL ovf_mem3: got %h want %h", v, modelMem[3]); end
        pulseStart();
        checks++; if (ld_err !== 1'b0) begin failures++; $display("[TB] FAIL restart_ld_err: got %b want 0", ld_err); end
        checks++; if (ld_words !== '0) begin failures++; $display("[TB] FAIL restart_ld_words: got %0d want 0", ld_words); end
        sendByte(8'h5A, 1, s);
        waitIdle();
        imgBytes = '{8'h5A};
        modelLoad();
        checks++; if (ld_words !== 3'd1) begin failures++; $display("[TB] FAIL restart_load_words: got %0d want 1", ld_words); end
        doFetch(0, v);
        checks++; if (v !== 32'h5A000000) begin failures++; $display("[TB] FAIL restart_mem0: got %h want 5a000000", v); end
    endtask

    task automatic test_reset_midload();
        logic [31:0] v;
        logic [31:0] word0;
        int s;
        imgBytes.delete();
        for (int i = 0; i < 6; i++) imgBytes.push_back(8'($urandom));
        word0 = {imgBytes[0], imgBytes[1], imgBytes[2], imgBytes[3]};
        pulseStart();
        for (int i = 0; i < 6; i++) sendByte(imgBytes[i], 0, s);
        #1;
        rst = 1'b0;
        #2;
        checks++; if (loading !== 1'b0) begin failures++; $display("[TB] FAIL midrst_loading: got %b want 0", loading); end
        checks++; if (ld_words !== '0) begin failures++; $display("[TB] FAIL midrst_ld_words: got %0d want 0", ld_words); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ld_ready: got %b want 0", ld_ready); end
        rst = 1'b1;
        modelMem[0]   = word0;
        modelKnown[0] = 1;
        doFetch(0, v);
        checks++; if (v !== modelMem[0]) begin failures++; $display("[TB] FAIL midrst_mem0: got %h want %h", v, modelMem[0]); end
        doFetch(1, v);
        checks++; if (v !== modelMem[1]) begin failures++; $display("[TB] FAIL midrst_mem1_untouched: got %h want %h", v, modelMem[1]); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_partial_word();
        test_fetch_while_loading();
        test_back_to_back();
        test_random_images();
        test_overflow_restart();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
